// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and the golden adder model for the ripple-carry adder slice.
// The golden function is used by the verification bench and is not part of the datapath.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 4;

  // Returns {cout,sum} = a + b + cin, truncated to width+1 bits.
  function automatic logic [63:0] golden_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        cin,
                                             input int          width);
    logic [63:0] full;
    full = {32'b0, a} + {32'b0, b} + {63'b0, cin};
    return full & ((64'd1 << (width + 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for ripple_carry_adder.
// The master drives operands and consumes results; the adder is the slave.
interface ripple_carry_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/ripple_carry_adder_full_adder.sv
// One bit of the ripple chain: purely combinational full adder.
// X or Z on an input is left to propagate naturally through the gate equations.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign sum    = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with one registered output stage (1-cycle latency).
// The carry chain runs the full width with no look-ahead; WIDTH is legal from 1 to 32.
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ripple_carry_adder_if.slave  bus
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  assign w_carry[0] = bus.cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      full_adder_1bit u_fa (
        .a    (bus.a[gi]),
        .b    (bus.b[gi]),
        .cin  (w_carry[gi]),
        .sum  (w_sum[gi]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

  // Result registers hold their value when no new operands arrive; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH = 4 (directed + exhaustive)
// and WIDTH = 1 / 8 (random), all compared against hand values or adder_pkg::golden_add.
module tb_ripple_carry_adder;
  import adder_pkg::*;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  ripple_carry_adder_if #(.WIDTH(4)) if4 ();
  ripple_carry_adder_if #(.WIDTH(1)) if1 ();
  ripple_carry_adder_if #(.WIDTH(8)) if8 ();

  ripple_carry_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  ripple_carry_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  ripple_carry_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Packs {out_valid,cout,sum} of the 4-bit adder into one comparison.
  task automatic checkResult4(input string tag, input logic expValid,
                              input logic expCout, input logic [3:0] expSum);
    checkOutput(tag, {58'b0, if4.out_valid, if4.cout, if4.sum},
                {58'b0, expValid, expCout, expSum});
  endtask

  // Drives one operand set to the 4-bit adder and waits until just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [3:0] a,
                               input logic [3:0] b, input logic cin);
    if4.in_valid = v;
    if4.a        = a;
    if4.b        = b;
    if4.cin      = cin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] exp1;
    logic [63:0] exp4;
    logic [63:0] exp8;
    logic [3:0]  s4a;
    logic [3:0]  s4b;
    logic        s4c;
    logic        s1a;
    logic        s1b;
    logic        s1c;
    logic [7:0]  s8a;
    logic [7:0]  s8b;
    logic        s8c;

    checkCount = 0;
    errorCount = 0;

    rst_n        = 1'b0;
    if4.in_valid = 1'b1;
    if4.a        = 4'd15;
    if4.b        = 4'd15;
    if4.cin      = 1'b1;
    if1.in_valid = 1'b0;
    if1.a        = 1'b0;
    if1.b        = 1'b0;
    if1.cin      = 1'b0;
    if8.in_valid = 1'b0;
    if8.a        = 8'd0;
    if8.b        = 8'd0;
    if8.cin      = 1'b0;

    // Reset dominates even with valid operands present.
    #1;
    checkResult4("reset_initial", 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    checkResult4("reset_held", 1'b0, 1'b0, 4'd0);
    checkOutput("reset_w1", {61'b0, if1.out_valid, if1.cout, if1.sum}, 64'd0);
    checkOutput("reset_w8", {55'b0, if8.out_valid, if8.cout, if8.sum}, 64'd0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkResult4("first_after_reset", 1'b1, 1'b1, 4'd15);

    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0);
    checkResult4("add_5_3", 1'b1, 1'b0, 4'd8);
    applyStimulus(1'b1, 4'd4, 4'd5, 1'b0);
    checkResult4("add_4_5", 1'b1, 1'b0, 4'd9);
    applyStimulus(1'b1, 4'd2, 4'd3, 1'b1);
    checkResult4("add_2_3_c", 1'b1, 1'b0, 4'd6);
    applyStimulus(1'b1, 4'd4, 4'd2, 1'b0);
    checkResult4("add_4_2", 1'b1, 1'b0, 4'd6);

    applyStimulus(1'b1, 4'd15, 4'd0, 1'b1);
    checkResult4("ripple_15_0_c", 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'd8, 4'd8, 1'b0);
    checkResult4("wrap_8_8", 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b1);
    checkResult4("wrap_15_15_c", 1'b1, 1'b1, 4'd15);

    applyStimulus(1'b1, 4'd7, 4'd1, 1'b0);
    checkResult4("hold_load", 1'b1, 1'b0, 4'd8);
    applyStimulus(1'b0, 4'd3, 4'd3, 1'b0);
    checkResult4("hold_keep", 1'b0, 1'b0, 4'd8);
    applyStimulus(1'b0, 4'd9, 4'd9, 1'b1);
    checkResult4("hold_keep2", 1'b0, 1'b0, 4'd8);

    // Mid-cycle asynchronous reset must clear outputs without waiting for a clock edge.
    applyStimulus(1'b1, 4'd6, 4'd6, 1'b0);
    checkResult4("pre_async", 1'b1, 1'b0, 4'd12);
    #2;
    rst_n = 1'b0;
    #1;
    checkResult4("async_clear", 1'b0, 1'b0, 4'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd6, 4'd6, 1'b0);
    checkResult4("post_reset_idle", 1'b0, 1'b0, 4'd0);

    // Exhaustive 4-bit sweep in parallel with random 1-bit and 8-bit traffic, back to back.
    for (int i = 0; i < 512; i++) begin
      s4a = 4'(i >> 5);
      s4b = 4'(i >> 1);
      s4c = 1'(i);
      s1a = 1'($urandom);
      s1b = 1'($urandom);
      s1c = 1'($urandom);
      s8a = 8'($urandom);
      s8b = 8'($urandom);
      s8c = 1'($urandom);

      if1.in_valid = 1'b1;
      if1.a        = s1a;
      if1.b        = s1b;
      if1.cin      = s1c;
      if8.in_valid = 1'b1;
      if8.a        = s8a;
      if8.b        = s8b;
      if8.cin      = s8c;
      applyStimulus(1'b1, s4a, s4b, s4c);

      exp4 = golden_add({28'b0, s4a}, {28'b0, s4b}, s4c, 4);
      exp1 = golden_add({31'b0, s1a}, {31'b0, s1b}, s1c, 1);
      exp8 = golden_add({24'b0, s8a}, {24'b0, s8b}, s8c, 8);
      checkOutput("sweep_w4", {59'b0, if4.cout, if4.sum}, exp4);
      checkOutput("rand_w1", {62'b0, if1.cout, if1.sum}, exp1);
      checkOutput("rand_w8", {55'b0, if8.cout, if8.sum}, exp8);
      if (i == 511) begin
        checkOutput("sweep_valid_w4", {63'b0, if4.out_valid}, 64'd1);
        checkOutput("sweep_valid_w8", {63'b0, if8.out_valid}, 64'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
